rom_adder_array_top: RTL and testbench

Self-contained, port-less (clock/reset only) arithmetic block: an internal ROM holds 2·N operand words, a sequencer streams them out after reset, and N result registers each capture the modulo-2^BW sum of one operand pair. Results, ROM contents and status are observed hierarchically by the system bench; the block is the top of its simulation hierarchy. ROM contents are loaded at time zero from a binary text file by the environment.

---
 rtl/rom_adder_array_top.sv | 118 +++++++++++
 tb/tb_rom_adder_array_top.sv | 120 ++++++++++++
 2 files changed

// File: rtl/rom_adder_array_top.sv
// rom_adder_array_top: a ROM of 2*N operand words is streamed out once after
// reset. Each even/odd word pair is summed modulo 2^BW into one result lane.
// done rises when the last lane is written and holds until the next reset.

module rom_adder_array_rom #(
  parameter int unsigned BW    = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  output logic [BW-1:0] data_o
);

  // Read-only contents; the environment loads this array before simulation starts.
  logic [BW-1:0] mem [0:DEPTH-1];
  logic [AW-1:0] addr_q;

  // Register the address; the word for that address is readable in the following cycle.
  always_ff @(posedge clk) begin
    addr_q <= addr_i;
  end

  assign data_o = mem[addr_q];

endmodule

module rom_adder_array_top #(
  parameter int unsigned BW = 8,
  parameter int unsigned N  = 4
) (
  input  logic clk,
  input  logic rst_n
);

  localparam int unsigned DEPTH = 2 * N;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;       // address of the word currently on rom_data
  logic [BW-1:0] latch_q, latch_d;   // even-address operand awaiting its partner
  logic [AW-1:0] rom_addr;
  logic [BW-1:0] rom_data;
  logic          last;

  logic [BW-1:0] adder_outputs [N-1:0];
  logic          done;

  rom_adder_array_rom #(
    .BW    (BW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) rom_instance (
    .clk    (clk),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  assign last = (cnt_q == AW'(DEPTH - 1));

  // Next-state and ROM address: the ROM is always fed one address ahead of cnt_q,
  // so the word for cnt_q is already on rom_data while it is being consumed.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rom_addr = cnt_q;
    latch_d  = latch_q;
    case (state_q)
      IDLE: begin
        state_d  = FETCH;
        rom_addr = '0;
        cnt_d    = '0;
      end
      FETCH: begin
        if (!cnt_q[0]) latch_d = rom_data;
        if (last) begin
          state_d = DONE;
        end else begin
          rom_addr = cnt_q + AW'(1);
          cnt_d    = cnt_q + AW'(1);
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      latch_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
    end
  end

  // Result lanes: lane i captures latch + data when the odd word 2i+1 arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) adder_outputs[i] <= '0;
      done <= 1'b0;
    end else if (state_q == FETCH) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (cnt_q == AW'(2 * i + 1)) adder_outputs[i] <= latch_q + rom_data;
      end
      if (last) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rom_adder_array_top.sv
// Bench for rom_adder_array_top: directed and random ROM images, per-cycle
// check of every lane and done against a timing/arithmetic reference model.

module tb_rom_adder_array_top;

  logic clk = 1'b0;
  logic rst_n;

  int vectors = 0;
  int miscompares = 0;
  int unsigned rom_img [8];

  always #5 clk = ~clk;

  rom_adder_array_top #(.BW(8), .N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  rom_adder_array_top #(.BW(16), .N(1)) dut16 (
    .clk   (clk),
    .rst_n (rst_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_rom();
    for (int k = 0; k < 8; k++) dut.rom_instance.mem[k] = 8'(rom_img[k]);
  endtask

  function automatic int unsigned lane_sum(input int i);
    return (rom_img[2*i] + rom_img[2*i+1]) % 256;
  endfunction

  // Releases reset at a falling edge, then checks every lane after each rising edge.
  task automatic run_seq(input int ncyc);
    rst_n = 1'b1;
    for (int e = 1; e <= ncyc; e++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        chk($sformatf("lane%0d_edge%0d", i, e), 32'(dut.adder_outputs[i]),
            (e >= 2*i + 3) ? lane_sum(i) : 0);
      chk($sformatf("done_edge%0d", e), 32'(dut.done), (e >= 9) ? 1 : 0);
      chk($sformatf("w16_lane0_edge%0d", e), 32'(dut16.adder_outputs[0]), (e >= 3) ? 32'h1 : 32'h0);
      chk($sformatf("w16_done_edge%0d", e), 32'(dut16.done), (e >= 3) ? 1 : 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_lane%0d", tag, i), 32'(dut.adder_outputs[i]), 0);
    chk({tag, "_done"}, 32'(dut.done), 0);
    chk({tag, "_w16_lane0"}, 32'(dut16.adder_outputs[0]), 0);
    chk({tag, "_w16_done"}, 32'(dut16.done), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rom_img = '{1, 2, 3, 4, 5, 6, 7, 8};
    load_rom();
    dut16.rom_instance.mem[0] = 16'hFFFF;
    dut16.rom_instance.mem[1] = 16'h0002;
    @(negedge clk);
    check_all_zero("reset");

    // Basic sums with progressive fill
    run_seq(10);
    chk("basic_lane0", 32'(dut.adder_outputs[0]), 3);
    chk("basic_lane1", 32'(dut.adder_outputs[1]), 7);
    chk("basic_lane2", 32'(dut.adder_outputs[2]), 11);
    chk("basic_lane3", 32'(dut.adder_outputs[3]), 15);

    // Hold in DONE for 50 extra cycles
    repeat (50) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("hold_lane%0d", i), 32'(dut.adder_outputs[i]), lane_sum(i));
    chk("hold_done", 32'(dut.done), 1);
    chk("hold_w16_lane0", 32'(dut16.adder_outputs[0]), 32'h1);
    for (int k = 0; k < 8; k++)
      chk($sformatf("hold_mem%0d", k), 32'(dut.rom_instance.mem[k]), rom_img[k]);

    // Reset mid-run: drop reset between edges 5 and 6, check without a clock edge
    rst_n = 1'b0;
    @(negedge clk);
    run_seq(5);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    run_seq(11);

    // Overflow wrap
    rst_n = 1'b0;
    rom_img = '{200, 100, 3, 4, 5, 6, 255, 1};
    load_rom();
    @(negedge clk);
    run_seq(11);
    chk("wrap_lane0", 32'(dut.adder_outputs[0]), 44);
    chk("wrap_lane3", 32'(dut.adder_outputs[3]), 0);

    // Random ROM images
    for (int r = 0; r < 4; r++) begin
      rst_n = 1'b0;
      for (int k = 0; k < 8; k++) rom_img[k] = $urandom_range(0, 255);
      load_rom();
      @(negedge clk);
      run_seq(11);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
